gmii_tx_arbiter: RTL and testbench

Frame-granular round-robin arbiter that shares one GMII transmit link between up to NUM_PORTS traffic_generator_gmii instances. Each generator requests the link, waits for a grant, then streams one frame; the arbiter muxes the granted port onto the shared GMII and enforces a minimum inter-frame gap. It sits between the generator GMII outputs and the PHY/MAC-facing GMII, or the traffic_analyzer_gmii in simulation.

---
 rtl/gmii_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_gmii_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one GMII transmit link between
// NUM_PORTS generators, with start-of-frame timeout and enforced inter-frame gap.
module gmii_tx_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int IFG_OCTETS    = 12,
    parameter int START_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   req,
    output logic [NUM_PORTS-1:0]   gnt,
    input  logic [8*NUM_PORTS-1:0] in_gmii_d,
    input  logic [NUM_PORTS-1:0]   in_gmii_en,
    input  logic [NUM_PORTS-1:0]   in_gmii_er,
    output logic [7:0]             gmii_d,
    output logic                   gmii_en,
    output logic                   gmii_er,
    output logic [2:0]             active_port,
    output logic                   timeout_pulse,
    output logic [31:0]            frames_sent
);

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int IW = $clog2(IFG_OCTETS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_OCTETS);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, FRAME, IFG} state_t;

    state_t        state, state_n;
    logic [2:0]    ptr;
    logic [TW-1:0] timer;
    logic [IW-1:0] idle_cnt;

    // Inputs widened to the full 8-port space so a 3-bit port index always fits.
    logic [7:0]  req_pad, en_pad, er_pad;
    logic [63:0] d_pad;
    logic        sel_req, sel_en, sel_er;
    logic [7:0]  sel_d;

    logic [2:0]  rr_sel;
    logic        rr_hit;
    logic [3:0]  scan_idx;
    logic        do_grant, do_release, do_timeout, do_done;

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p == 3'(NUM_PORTS - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [2:0] idx);
        logic [NUM_PORTS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (3'(k) == idx) v[k] = 1'b1;
        end
        return v;
    endfunction

    assign req_pad = 8'(req);
    assign en_pad  = 8'(in_gmii_en);
    assign er_pad  = 8'(in_gmii_er);
    assign d_pad   = 64'(in_gmii_d);
    assign sel_req = req_pad[active_port];
    assign sel_en  = en_pad[active_port];
    assign sel_er  = er_pad[active_port];
    assign sel_d   = d_pad[{active_port, 3'b000} +: 8];

    // First requesting port at or after ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        rr_hit   = 1'b0;
        rr_sel   = ptr;
        scan_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = {1'b0, ptr} + 4'(k);
            if (scan_idx >= 4'(NUM_PORTS)) scan_idx = scan_idx - 4'(NUM_PORTS);
            if (!rr_hit && req_pad[scan_idx[2:0]]) begin
                rr_hit = 1'b1;
                rr_sel = scan_idx[2:0];
            end
        end
    end

    always_comb begin
        state_n    = state;
        do_grant   = 1'b0;
        do_release = 1'b0;
        do_timeout = 1'b0;
        do_done    = 1'b0;
        case (state)
            IDLE: begin
                if (rr_hit) begin
                    state_n  = WAIT_SOF;
                    do_grant = 1'b1;
                end
            end
            WAIT_SOF: begin
                if (sel_en) begin
                    state_n = FRAME;
                end else if (!sel_req) begin
                    state_n    = IDLE;
                    do_release = 1'b1;
                end else if (timer == TMO_LAST) begin
                    state_n    = IDLE;
                    do_release = 1'b1;
                    do_timeout = 1'b1;
                end
            end
            FRAME: begin
                if (!sel_en) begin
                    state_n    = IFG;
                    do_release = 1'b1;
                    do_done    = 1'b1;
                end
            end
            IFG: begin
                if (idle_cnt == IFG_LAST) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            gnt           <= '0;
            active_port   <= '0;
            timer         <= '0;
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
            frames_sent   <= '0;
            gmii_d        <= '0;
            gmii_en       <= 1'b0;
            gmii_er       <= 1'b0;
        end else begin
            state         <= state_n;
            timeout_pulse <= do_timeout;

            if (do_grant) begin
                gnt         <= port_onehot(rr_sel);
                active_port <= rr_sel;
                timer       <= '0;
            end else if (do_release) begin
                gnt <= '0;
                ptr <= next_port(active_port);
            end

            if (state == WAIT_SOF && state_n == WAIT_SOF) timer <= timer + 1'b1;

            if (do_done) begin
                frames_sent <= frames_sent + 32'd1;
                idle_cnt    <= IW'(1);
            end else if (state == IFG) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // Output stage: only the granted port is ever registered onto the link.
            if (state == WAIT_SOF || state == FRAME) begin
                gmii_d  <= sel_d;
                gmii_en <= sel_en;
                gmii_er <= sel_er;
            end else begin
                gmii_d  <= '0;
                gmii_en <= 1'b0;
                gmii_er <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: behavioural generators push expected octets,
// a monitor checks octets, grant order, gaps, timeouts and counters.
module tb_gmii_tx_arbiter;

    localparam int NP  = 4;
    localparam int IFG = 12;
    localparam int TMO = 16;
    localparam int M_NORM = 0, M_NEVER = 1, M_WD = 2, M_ROGUE = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req = '0;
    logic [NP-1:0]   gnt;
    logic [8*NP-1:0] in_d = '0;
    logic [NP-1:0]   in_en = '0;
    logic [NP-1:0]   in_er = '0;
    logic [7:0]      gmii_d;
    logic            gmii_en, gmii_er;
    logic [2:0]      active_port;
    logic            timeout_pulse;
    logic [31:0]     frames_sent;

    int vectors = 0, miscompares = 0;
    logic [8:0] exp_q[$];
    int mode[NP], left[NP], pos[NP], len[NP], flen[NP], dly_max[NP], dly[NP];
    bit sending[NP];
    int model_frames = 0, exp_timeouts = 0, timeouts_seen = 0;
    logic [NP-1:0] req_s = '0;
    logic          rst_s = 1'b1;

    gmii_tx_arbiter #(.NUM_PORTS(NP), .IFG_OCTETS(IFG), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .in_gmii_d(in_d), .in_gmii_en(in_en), .in_gmii_er(in_er),
        .gmii_d(gmii_d), .gmii_en(gmii_en), .gmii_er(gmii_er),
        .active_port(active_port), .timeout_pulse(timeout_pulse),
        .frames_sent(frames_sent)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NP-1:0] r, input int p);
        for (int k = 0; k < NP; k++) if (r[(p + k) % NP]) return (p + k) % NP;
        return -1;
    endfunction

    // ---------------- behavioural generators ----------------
    task automatic drive_idle(input int p);
        in_d[8*p +: 8] = 8'h00;
        in_en[p] = 1'b0;
        in_er[p] = 1'b0;
    endtask

    task automatic drive_octet(input int p);
        logic [7:0] dv;
        logic ev;
        dv = 8'($urandom);
        ev = ($urandom_range(0, 15) == 0);
        in_d[8*p +: 8] = dv;
        in_en[p] = 1'b1;
        in_er[p] = ev;
        exp_q.push_back({ev, dv});
        pos[p]++;
    endtask

    task automatic cfg(input int p, input int nfr, input int m, input int fl, input int dm);
        mode[p] = m;
        left[p] = nfr;
        flen[p] = fl;
        dly_max[p] = dm;
        dly[p] = $urandom_range(0, dm);
        sending[p] = 0;
        req[p] = (m != M_ROGUE) && (nfr > 0);
        if (m == M_NEVER && nfr > 0) exp_timeouts++;
    endtask

    task automatic gen_port(input int p);
        case (mode[p])
            M_ROGUE: begin
                in_d[8*p +: 8] = 8'hAA;
                in_en[p] = 1'b1;
                in_er[p] = 1'b0;
            end
            M_NEVER: begin
                if (timeout_pulse && active_port == 3'(p) && left[p] > 0) begin
                    req[p] = 1'b0;
                    left[p] = 0;
                end
            end
            M_WD: begin
                if (gnt[p] && req[p]) begin
                    req[p] = 1'b0;
                    left[p] = 0;
                end
            end
            default: begin
                if (sending[p]) begin
                    if (pos[p] < len[p]) begin
                        drive_octet(p);
                    end else begin
                        drive_idle(p);
                        sending[p] = 0;
                        left[p]--;
                        model_frames++;
                        req[p] = (left[p] > 0);
                        dly[p] = $urandom_range(0, dly_max[p]);
                    end
                end else if (gnt[p] && req[p] && left[p] > 0) begin
                    if (dly[p] > 0) begin
                        dly[p]--;
                    end else begin
                        sending[p] = 1;
                        pos[p] = 0;
                        len[p] = (flen[p] > 0) ? flen[p] : int'($urandom_range(20, 120));
                        drive_octet(p);
                    end
                end
            end
        endcase
    endtask

    initial forever begin
        @(negedge clk);
        for (int p = 0; p < NP; p++) gen_port(p);
    end

    initial forever begin
        @(posedge clk);
        req_s = req;
        rst_s = rst;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int model_ptr, cur_port, gcnt, idle_run, exp_p;
        bit seen_frame, en_prev;
        logic [NP-1:0] gnt_prev;
        logic [8:0] e;
        model_ptr = 0; cur_port = 0; gcnt = 0; idle_run = 0;
        seen_frame = 0; en_prev = 0; gnt_prev = '0;
        forever begin
            @(negedge clk);
            if (rst_s) begin
                model_ptr = 0; gcnt = 0; idle_run = 0;
                seen_frame = 0; en_prev = 0; gnt_prev = '0;
                continue;
            end
            gcnt++;
            if (gmii_en) begin
                if (!en_prev && seen_frame) chk("ifg_gap_ok", 32'(idle_run >= IFG + 1), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_octet", {23'd0, gmii_er, gmii_d}, 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("octet", {23'd0, gmii_er, gmii_d}, {23'd0, e});
                end
                idle_run = 0;
                seen_frame = 1;
            end else begin
                chk("idle_lane", {23'd0, gmii_er, gmii_d}, 0);
                idle_run++;
            end
            en_prev = gmii_en;
            if (gnt !== gnt_prev) begin
                if (gnt != '0) begin
                    exp_p = rr_pick(req_s, model_ptr);
                    chk("gnt_from_zero", gnt_prev, 0);
                    chk("gnt_port", gnt, (exp_p < 0) ? 0 : (32'd1 << exp_p));
                    chk("active_port", active_port, exp_p);
                    cur_port = exp_p;
                    gcnt = 0;
                end else begin
                    model_ptr = (cur_port + 1) % NP;
                end
                gnt_prev = gnt;
            end
            if (timeout_pulse) begin
                timeouts_seen++;
                chk("timeout_latency", gcnt, TMO);
                chk("timeout_gnt_low", gnt, 0);
            end
        end
    end

    // ---------------- phase helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int p = 0; p < NP; p++) begin
            mode[p] = M_NORM; left[p] = 0; sending[p] = 0; req[p] = 1'b0;
            drive_idle(p);
        end
        exp_q.delete();
        model_frames = 0; exp_timeouts = 0; timeouts_seen = 0;
        @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_gmii_en", gmii_en, 0);
        chk("rst_gmii_d", gmii_d, 0);
        chk("rst_gmii_er", gmii_er, 0);
        chk("rst_active_port", active_port, 0);
        chk("rst_timeout_pulse", timeout_pulse, 0);
        chk("rst_frames_sent", frames_sent, 0);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            ok = (gnt == '0) && (exp_q.size() == 0);
            for (int p = 0; p < NP; p++) ok = ok && (left[p] == 0) && !sending[p];
        end
        chk({name, "_completed"}, 32'(ok), 1);
        repeat (IFG + 4) @(negedge clk);
        #1;
        chk({name, "_frames_sent"}, frames_sent, model_frames);
        chk({name, "_timeouts"}, timeouts_seen, exp_timeouts);
    endtask

    task automatic wait_gnt(input logic [NP-1:0] mask, input int budget, output logic [NP-1:0] got);
        got = '0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            if ((gnt & mask) != '0) begin
                got = gnt;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NP-1:0] got;
        int m, nf;
        for (int p = 0; p < NP; p++) begin
            mode[p] = M_NORM; left[p] = 0; pos[p] = 0; len[p] = 0;
            flen[p] = 0; dly_max[p] = 0; dly[p] = 0; sending[p] = 0;
        end
        repeat (2) @(negedge clk);
        do_reset();

        // single port 2, 72-octet frame, grant one cycle after req
        @(negedge clk); #1;
        cfg(2, 1, M_NORM, 72, 0);
        @(posedge clk); #1;
        chk("p2_grant_latency", gnt, 4'b0100);
        wait_done("p2_single", 400);
        chk("p2_gnt_low", gnt, 0);

        // all ports, continuous requests, strict rotation
        @(negedge clk); #1;
        for (int p = 0; p < NP; p++) cfg(p, 2, M_NORM, 72, 0);
        wait_done("all_rr", 2500);

        // port 1 never starts
        @(negedge clk); #1;
        cfg(0, 1, M_NORM, 64, 1);
        cfg(1, 1, M_NEVER, 0, 0);
        cfg(2, 1, M_NORM, 0, 1);
        cfg(3, 1, M_NORM, 0, 1);
        wait_done("timeout", 2000);

        // rogue port 3 drives en while port 0 owns the link
        @(negedge clk); #1;
        cfg(3, 0, M_ROGUE, 0, 0);
        cfg(0, 2, M_NORM, 0, 2);
        wait_done("rogue", 1000);
        mode[3] = M_NORM;
        drive_idle(3);

        // reset mid-frame on port 1
        @(negedge clk); #1;
        cfg(1, 1, M_NORM, 72, 0);
        wait_gnt(4'b0010, 100, got);
        chk("p1_granted", got, 4'b0010);
        repeat (10) @(negedge clk);
        do_reset();
        @(negedge clk); #1;
        for (int p = 0; p < NP; p++) cfg(p, 1, M_NORM, 72, 0);
        wait_gnt(4'b1111, 100, got);
        chk("post_reset_first_gnt", got, 4'b0001);
        wait_done("post_reset", 1500);

        // port 0 withdraws in WAIT_SOF, port 1 follows
        @(negedge clk); #1;
        cfg(0, 1, M_WD, 0, 0);
        cfg(1, 1, M_NORM, 0, 0);
        wait_gnt(4'b0001, 100, got);
        chk("wd_p0_granted", got, 4'b0001);
        wait_gnt(4'b1110, 100, got);
        chk("wd_next_p1", got, 4'b0010);
        wait_done("withdraw", 600);

        // randomized rounds
        for (int r = 0; r < 4; r++) begin
            @(negedge clk); #1;
            for (int p = 0; p < NP; p++) begin
                m  = ($urandom_range(0, 7) == 0) ? M_NEVER : M_NORM;
                nf = (m == M_NEVER) ? 1 : int'($urandom_range(0, 3));
                cfg(p, nf, m, 0, 3);
            end
            wait_done("random", 5000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
